// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and transmitter-side signals of the UART TX
// round-robin arbiter.
//   i_req      [N_REQ]          level requests, held until granted
//   i_data     [N_REQ*DATA_W]   packed bytes, requester k at [k*DATA_W +: DATA_W]
//   o_gnt      [N_REQ]          one-hot grant pulse
//   o_tx_data  [DATA_W]         latched byte to the transmitter
//   o_tx_start                  one-cycle start pulse to the transmitter
//   i_tx_ready                  transmitter idle flag (high = idle)
//   o_owner    [clog2(N_REQ)]   current / last granted requester
//   o_busy                      arbiter not idle
//   o_err                       sticky watchdog flag
// Modport slave is the arbiter; modport master is the client/transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        o_gnt;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_ready;
    logic [IDX_W-1:0]        o_owner;
    logic                    o_busy;
    logic                    o_err;

    modport slave (
        input  i_req, i_data, i_tx_ready,
        output o_gnt, o_tx_data, o_tx_start, o_owner, o_busy, o_err
    );

    modport master (
        output i_req, i_data, i_tx_ready,
        input  o_gnt, o_tx_data, o_tx_start, o_owner, o_busy, o_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmit path among N_REQ byte
// producers. In IDLE it picks the next requester after the last winner,
// latches its byte, pulses o_tx_start, then follows the transmitter's ready
// flag (fall = frame accepted, rise = frame done) before arbitrating again.
// A watchdog flags a transmitter that never drops ready after a start.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - uart_tx_arbiter_if.slave (requests, data, grant, TX handshake,
//          owner, busy, error)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ACK_TO = 15
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int              IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]      ACK_TO_C = 4'(ACK_TO);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_tx_data;
    logic [3:0]          r_cnt;
    logic                r_err;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_winner;
    logic                w_found;
    logic                w_grant;
    logic                w_timeout;

    // Round-robin scan: first asserted request starting just after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx    = IDX_W'((int'(r_last) + i) % N_REQ);
            w_winner = (!w_found && bus.i_req[w_idx]) ? w_idx : w_winner;
            w_found  = w_found | bus.i_req[w_idx];
        end
    end

    // Next-state logic, grant qualification and watchdog expiry.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && bus.i_tx_ready) begin
                    w_grant = 1'b1;
                    w_next  = LAUNCH;
                end else begin
                    w_next  = IDLE;
                end
            end
            LAUNCH: begin
                w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A ready fall takes precedence over the watchdog in the same cycle.
                if (!bus.i_tx_ready) begin
                    w_next = WAIT_DONE;
                end else if (r_cnt == ACK_TO_C) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_next = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (bus.i_tx_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = WAIT_DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: latched byte, round-robin pointer, owner, watchdog, error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= IDX_W'(N_REQ - 1);
            r_owner   <= '0;
            r_tx_data <= '0;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_tx_data <= bus.i_data[w_winner*DATA_W +: DATA_W];
                r_last    <= w_winner;
                r_owner   <= w_winner;
            end
            if (r_state == LAUNCH) begin
                r_cnt <= 4'd0;
            end else if (r_state == WAIT_ACK && bus.i_tx_ready && !w_timeout) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Grant is combinational in the grant cycle; held off while reset is asserted.
    always_comb begin
        if (w_grant && !rst) begin
            bus.o_gnt = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
        end else begin
            bus.o_gnt = '0;
        end
    end

    assign bus.o_tx_start = (r_state == LAUNCH);
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_owner    = r_owner;
    assign bus.o_err      = r_err;

endmodule
